// File: rtl/sap1_pkg.sv
// SAP-1 shared definitions: control-word bit positions, canned microcode
// words and the instruction opcodes decoded by the controller.
package sap1_pkg;

    localparam int unsigned CW_W = 12;

    // Control-word bit positions
    localparam int unsigned CP   = 11;
    localparam int unsigned EP   = 10;
    localparam int unsigned LM_N = 9;
    localparam int unsigned CE_N = 8;
    localparam int unsigned LI_N = 7;
    localparam int unsigned EI_N = 6;
    localparam int unsigned LA_N = 5;
    localparam int unsigned EA   = 4;
    localparam int unsigned SU   = 3;
    localparam int unsigned EU   = 2;
    localparam int unsigned LB_N = 1;
    localparam int unsigned LO_N = 0;

    // Canned microcode words
    localparam logic [CW_W-1:0] CW_NOP      = 12'h3E3;
    localparam logic [CW_W-1:0] CW_FETCH_T1 = 12'h5E3;  // PC -> MAR
    localparam logic [CW_W-1:0] CW_FETCH_T2 = 12'hBE3;  // PC++
    localparam logic [CW_W-1:0] CW_FETCH_T3 = 12'h263;  // RAM[MAR] -> IR

    typedef enum logic [3:0] {
        LDA = 4'h0,
        ADD = 4'h1,
        SUB = 4'h2,
        OUT = 4'hE,
        HLT = 4'hF
    } opcode_e;

endpackage

// File: rtl/sap1_ram16x8.sv
// SAP-1 program/data memory.
// Ports: clk_i (write clock), we_i (write enable), waddr_i/wdata_i (write
// port), raddr_i (read address), rdata_o (asynchronous read data).
// Contents are not reset.
module sap1_ram16x8 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: executes the 12-bit control word on the W-bus registers
// (PC, MAR, RAM, IR, A, B, ALU, OUT) and returns IR[7:4] to the controller.
// Ports:
//   CLK, CLR        clock, asynchronous active-high reset
//   cntrl_bus       control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//   prog_we/addr/data  RAM program port, only honoured while CLR=1
//   opcode          IR upper nibble
//   out_port        output register
//   wbus, pc        debug views of the bus and program counter
//   bus_conflict    sticky flag: more than one bus driver on some posedge
module sap1_datapath
    import sap1_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [CW_W-1:0]   cntrl_bus,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] wbus,
    output logic [ADDR_W-1:0] pc,
    output logic              bus_conflict
);

    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic              conflict_q, conflict_d;

    logic [DATA_W-1:0] ram_rdata, alu, b_op, bus;
    logic [4:0]        drv;
    logic              multi_drv;

    // Active-high decoded control strobes
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    assign cp = cntrl_bus[CP];
    assign ep = cntrl_bus[EP];
    assign lm = ~cntrl_bus[LM_N];
    assign ce = ~cntrl_bus[CE_N];
    assign li = ~cntrl_bus[LI_N];
    assign ei = ~cntrl_bus[EI_N];
    assign la = ~cntrl_bus[LA_N];
    assign ea = cntrl_bus[EA];
    assign su = cntrl_bus[SU];
    assign eu = cntrl_bus[EU];
    assign lb = ~cntrl_bus[LB_N];
    assign lo = ~cntrl_bus[LO_N];

    // Program writes are gated by CLR so a running machine cannot modify RAM.
    sap1_ram16x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (CLR & prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (mar_q),
        .rdata_o (ram_rdata)
    );

    // Subtract as A + ~B + 1; carry out is dropped by truncation.
    always_comb begin
        b_op = su ? ~b_q : b_q;
        alu  = a_q + b_op + {{(DATA_W-1){1'b0}}, su};
    end

    // Fixed-priority bus mux: Ep > CE > Ei > Ea > Eu.
    always_comb begin
        bus = '0;
        if (ep) begin
            bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
        end else if (ce) begin
            bus = ram_rdata;
        end else if (ei) begin
            bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
        end else if (ea) begin
            bus = a_q;
        end else if (eu) begin
            bus = alu;
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign drv       = {ep, ce, ei, ea, eu};
    assign multi_drv = |(drv & (drv - 5'd1));

    always_comb begin
        pc_d       = cp ? pc_q + ADDR_W'(1) : pc_q;
        mar_d      = lm ? bus[ADDR_W-1:0] : mar_q;
        ir_d       = li ? bus : ir_q;
        a_d        = la ? bus : a_q;
        b_d        = lb ? bus : b_q;
        out_d      = lo ? bus : out_q;
        conflict_d = conflict_q | multi_drv;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pc_q       <= '0;
            mar_q      <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            out_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            mar_q      <= mar_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            out_q      <= out_d;
            conflict_q <= conflict_d;
        end
    end

    assign opcode       = ir_q[DATA_W-1 -: 4];
    assign out_port     = out_q;
    assign wbus         = bus;
    assign pc           = pc_q;
    assign bus_conflict = conflict_q;

endmodule

// File: tb/tb_sap1_datapath.sv
module tb_sap1_datapath;
    import sap1_pkg::*;

    logic        CLK, CLR, prog_we, bus_conflict;
    logic [11:0] cntrl_bus;
    logic [3:0]  prog_addr, opcode, pc;
    logic [7:0]  prog_data, out_port, wbus;

    int n_tests = 0;
    int n_fail  = 0;

    sap1_datapath dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .cntrl_bus    (cntrl_bus),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .opcode       (opcode),
        .out_port     (out_port),
        .wbus         (wbus),
        .pc           (pc),
        .bus_conflict (bus_conflict)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Microcode words for the instruction set
    localparam logic [11:0] CW_IR_TO_MAR = 12'h1A3;
    localparam logic [11:0] CW_RAM_TO_A  = 12'h2C3;
    localparam logic [11:0] CW_RAM_TO_B  = 12'h2E1;
    localparam logic [11:0] CW_ADD_TO_A  = 12'h3C7;
    localparam logic [11:0] CW_SUB_TO_A  = 12'h3CF;
    localparam logic [11:0] CW_A_TO_OUT  = 12'h3F2;
    localparam logic [11:0] CW_A_ONLY    = 12'h3F3;
    localparam logic [11:0] CW_RAM_ONLY  = 12'h2E3;
    localparam logic [11:0] CW_CP_EP_LM  = 12'hDE3;
    localparam logic [11:0] CW_EP_EA     = 12'h7F3;

    // Reference machine state
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_a, m_b, m_out;
    logic [7:0] m_ram [16];
    bit         m_conf;

    function automatic logic [7:0] m_bus(input logic [11:0] cw);
        if (cw[EP])    return {4'h0, m_pc};
        if (!cw[CE_N]) return m_ram[m_mar];
        if (!cw[EI_N]) return {4'h0, m_ir[3:0]};
        if (cw[EA])    return m_a;
        if (cw[EU])    return cw[SU] ? 8'(m_a - m_b) : 8'(m_a + m_b);
        return 8'h00;
    endfunction

    function automatic int m_ndrv(input logic [11:0] cw);
        return int'(cw[EP]) + int'(!cw[CE_N]) + int'(!cw[EI_N]) + int'(cw[EA]) + int'(cw[EU]);
    endfunction

    task automatic m_step(input logic [11:0] cw);
        logic [7:0] b;
        b = m_bus(cw);
        if (!cw[LM_N]) m_mar = b[3:0];
        if (!cw[LI_N]) m_ir = b;
        if (!cw[LA_N]) m_a = b;
        if (!cw[LB_N]) m_b = b;
        if (!cw[LO_N]) m_out = b;
        if (cw[CP]) m_pc = 4'((m_pc + 1) % 16);
        if (m_ndrv(cw) > 1) m_conf = 1'b1;
    endtask

    task automatic m_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0; m_conf = 0;
    endtask

    task automatic run_cw(input logic [11:0] cw);
        @(negedge CLK);
        cntrl_bus = cw;
        @(posedge CLK);
        m_step(cw);
        #1;
    endtask

    task automatic assert_clr();
        @(negedge CLK);
        CLR = 1'b1;
        cntrl_bus = CW_NOP;
        m_reset();
    endtask

    task automatic release_clr();
        @(negedge CLK);
        CLR = 1'b0;
        cntrl_bus = CW_NOP;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge CLK);
        m_ram[a] = d;
        #1 prog_we = 1'b0;
    endtask

    // Leaves A=a, B=b, PC=F (machine otherwise fresh from reset)
    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        assert_clr();
        prog_write(4'hE, a);
        prog_write(4'hF, b);
        release_clr();
        repeat (14) run_cw(CW_FETCH_T2);
        run_cw(CW_FETCH_T1);
        run_cw(CW_RAM_TO_A);
        run_cw(CW_FETCH_T2);
        run_cw(CW_FETCH_T1);
        run_cw(CW_RAM_TO_B);
    endtask

    task automatic peek_a(input logic [7:0] exp, input string name);
        @(negedge CLK);
        cntrl_bus = CW_A_ONLY;
        #1;
        n_tests++;
        if (wbus !== exp) begin
            n_fail++;
            $display("FAIL %s: A got %h want %h", name, wbus, exp);
        end
        @(posedge CLK);
        m_step(CW_A_ONLY);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (pc !== 4'h0 || out_port !== 8'h00 || opcode !== 4'h0 || bus_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: pc=%h out=%h op=%h conf=%b want all 0",
                     pc, out_port, opcode, bus_conflict);
        end
        n_tests++;
        if (wbus !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_wbus: got %h want 00", wbus);
        end
    endtask

    task automatic test_program();
        logic [7:0] img [16];
        logic [3:0] exp_op [5];
        img = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h10, 8'h14, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_op = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF};
        for (int i = 0; i < 16; i++) prog_write(4'(i), img[i]);
        release_clr();
        for (int i = 0; i < 5; i++) begin
            run_cw(CW_FETCH_T1);
            run_cw(CW_FETCH_T2);
            run_cw(CW_FETCH_T3);
            n_tests++;
            if (opcode !== exp_op[i]) begin
                n_fail++;
                $display("FAIL prog_opcode[%0d]: got %h want %h", i, opcode, exp_op[i]);
            end
            case (exp_op[i])
                4'h0: begin run_cw(CW_IR_TO_MAR); run_cw(CW_RAM_TO_A); run_cw(CW_NOP); end
                4'h1: begin run_cw(CW_IR_TO_MAR); run_cw(CW_RAM_TO_B); run_cw(CW_ADD_TO_A); end
                4'h2: begin run_cw(CW_IR_TO_MAR); run_cw(CW_RAM_TO_B); run_cw(CW_SUB_TO_A); end
                4'hE: begin run_cw(CW_A_TO_OUT); run_cw(CW_NOP); run_cw(CW_NOP); end
                default: ;
            endcase
        end
        n_tests++;
        if (out_port !== 8'h0C) begin
            n_fail++;
            $display("FAIL prog_out: got %h want 0c", out_port);
        end
        n_tests++;
        if (pc !== 4'h5) begin
            n_fail++;
            $display("FAIL prog_pc: got %h want 5", pc);
        end
    endtask

    task automatic test_async_clear();
        run_cw(CW_EP_EA);  // make the conflict flag nonzero too
        @(negedge CLK);
        #2 CLR = 1'b1;
        #1;
        n_tests++;
        if (pc !== 4'h0 || out_port !== 8'h00 || opcode !== 4'h0 || bus_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clr: pc=%h out=%h op=%h conf=%b want all 0",
                     pc, out_port, opcode, bus_conflict);
        end
        #1 CLR = 1'b0;
        m_reset();
        run_cw(CW_FETCH_T1);
        @(negedge CLK);
        cntrl_bus = CW_RAM_ONLY;
        #1;
        n_tests++;
        if (wbus !== 8'h09) begin
            n_fail++;
            $display("FAIL clr_ram_kept: RAM[0] got %h want 09", wbus);
        end
        @(posedge CLK);
        m_step(CW_RAM_ONLY);
        #1;
    endtask

    task automatic test_arith_wrap();
        load_ab(8'hFF, 8'h01);
        run_cw(CW_ADD_TO_A);
        peek_a(8'h00, "add_wrap");
        run_cw(CW_SUB_TO_A);
        peek_a(8'hFF, "sub_wrap");
    endtask

    task automatic test_pc_wrap();
        assert_clr();
        release_clr();
        repeat (15) run_cw(CW_FETCH_T2);
        n_tests++;
        if (pc !== 4'hF) begin
            n_fail++;
            $display("FAIL pc_count: got %h want f", pc);
        end
        run_cw(CW_FETCH_T2);
        n_tests++;
        if (pc !== 4'h0) begin
            n_fail++;
            $display("FAIL pc_wrap: got %h want 0", pc);
        end
        repeat (3) run_cw(CW_FETCH_T2);
        run_cw(CW_CP_EP_LM);
        n_tests++;
        if (pc !== 4'h4) begin
            n_fail++;
            $display("FAIL cp_ep_pc: got %h want 4", pc);
        end
        @(negedge CLK);
        cntrl_bus = CW_RAM_ONLY;
        #1;
        n_tests++;
        if (wbus !== 8'hE0) begin  // RAM[3] from the program image, so MAR=3
            n_fail++;
            $display("FAIL cp_ep_mar: RAM[MAR] got %h want e0", wbus);
        end
        @(posedge CLK);
        m_step(CW_RAM_ONLY);
        #1;
    endtask

    task automatic test_back_to_back();
        load_ab(8'h05, 8'h03);
        run_cw(CW_ADD_TO_A);
        @(negedge CLK);
        cntrl_bus = CW_ADD_TO_A;
        #1;
        n_tests++;
        if (wbus !== 8'h0B) begin  // ALU sees A=08 after the first edge
            n_fail++;
            $display("FAIL rbw_mid: alu got %h want 0b", wbus);
        end
        @(posedge CLK);
        m_step(CW_ADD_TO_A);
        #1;
        peek_a(8'h0B, "rbw_final");
    endtask

    task automatic test_conflict();
        load_ab(8'h55, 8'h01);
        repeat (7) run_cw(CW_FETCH_T2);
        @(negedge CLK);
        cntrl_bus = CW_EP_EA;
        #1;
        n_tests++;
        if (wbus !== 8'h06 || bus_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_bus: wbus=%h conf=%b want 06/0", wbus, bus_conflict);
        end
        @(posedge CLK);
        m_step(CW_EP_EA);
        #1;
        n_tests++;
        if (bus_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_set: got %b want 1", bus_conflict);
        end
        repeat (3) run_cw(CW_NOP);
        n_tests++;
        if (bus_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_sticky: got %b want 1", bus_conflict);
        end
        assert_clr();
        #1;
        n_tests++;
        if (bus_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_clr: got %b want 0", bus_conflict);
        end
        release_clr();
    endtask

    task automatic test_random();
        logic [11:0] cw;
        logic [7:0]  eb;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                assert_clr();
                repeat (3) prog_write(4'($urandom), 8'($urandom));
                release_clr();
            end
            cw = 12'($urandom);
            // Mostly a single bus driver so the sticky flag doesn't saturate
            if ($urandom_range(0, 3) != 0) begin
                cw[EP] = 1'b0; cw[CE_N] = 1'b1; cw[EI_N] = 1'b1; cw[EA] = 1'b0; cw[EU] = 1'b0;
                case ($urandom_range(0, 5))
                    0: cw[EP] = 1'b1;
                    1: cw[CE_N] = 1'b0;
                    2: cw[EI_N] = 1'b0;
                    3: cw[EA] = 1'b1;
                    4: cw[EU] = 1'b1;
                    default: ;
                endcase
            end
            @(negedge CLK);
            cntrl_bus = cw;
            #1;
            eb = m_bus(cw);
            n_tests++;
            if (wbus !== eb) begin
                n_fail++;
                $display("FAIL rnd_wbus[%0d] cw=%h: got %h want %h", i, cw, wbus, eb);
            end
            @(posedge CLK);
            m_step(cw);
            #1;
            n_tests++;
            if (pc !== m_pc || opcode !== m_ir[7:4] || out_port !== m_out
                || bus_conflict !== m_conf) begin
                n_fail++;
                $display("FAIL rnd_state[%0d] cw=%h: pc=%h op=%h out=%h conf=%b want %h %h %h %b",
                         i, cw, pc, opcode, out_port, bus_conflict,
                         m_pc, m_ir[7:4], m_out, m_conf);
            end
        end
    endtask

    initial begin
        CLR = 1'b1;
        cntrl_bus = CW_NOP;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        m_reset();
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        test_reset();
        test_program();
        test_async_clear();
        test_arith_wrap();
        test_pc_wrap();
        test_back_to_back();
        test_conflict();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
